// File: rtl/duty_pkg.sv
// Shared definitions for the multi-channel duty ramp controller.
// Holds the command encodings, default parameters and the common clamp helper.
package duty_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam int DEF_WIDTH     = 12;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_DUTY_MAX  = 500;
  localparam int DEF_DUTY_MIN  = 0;
  localparam int DEF_DUTY_INIT = 100;
  localparam int DEF_STEP_DIV  = 10;
  localparam int DEF_SLEW      = 8;
  localparam int DEF_RAMP_DIV  = 4;

  typedef struct packed {
    logic        hit;
    logic [31:0] value;
  } clamp_t;

  // Wide enough for any legal duty word; callers narrow the result with a cast.
  function automatic clamp_t clampDuty(input logic [31:0] value,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    clamp_t res;
    res.hit   = 1'b0;
    res.value = value;
    if (value > hi) begin
      res.value = hi;
      res.hit   = 1'b1;
    end else if (value < lo) begin
      res.value = lo;
      res.hit   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/duty_ramp_ctrl_if.sv
// Command port of the duty ramp controller: valid/ready with channel, op and load data.
interface duty_ramp_ctrl_if #(
  parameter int WIDTH = duty_pkg::DEF_WIDTH,
  parameter int CH_W  = 2
);
  import duty_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_ch, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_op, cmd_data, output cmd_ready);

endinterface

// File: rtl/duty_ramp_lane.sv
// One channel: target/duty/sat registers, step and clamp datapath, and slew-limited ramp.
module duty_ramp_lane
  import duty_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DUTY_MAX  = DEF_DUTY_MAX,
  parameter int DUTY_MIN  = DEF_DUTY_MIN,
  parameter int DUTY_INIT = DEF_DUTY_INIT,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int SLEW      = DEF_SLEW
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_exec,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_duty,
  output logic             o_atTarget,
  output logic             o_sat
);

  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] MIN_X  = W1'(DUTY_MIN);
  localparam logic [WIDTH:0] DIV_X  = W1'(STEP_DIV);
  localparam logic [WIDTH:0] SLEW_X = W1'(SLEW);

  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_duty;
  logic             r_sat;

  logic [WIDTH:0]   w_tgtExt;
  logic [WIDTH:0]   w_stepRaw;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_upSum;
  clamp_t           w_upClamp;
  clamp_t           w_loadClamp;
  logic [WIDTH-1:0] w_nextTarget;
  logic             w_nextSat;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_slewStep;
  logic [WIDTH-1:0] w_nextDuty;

  // The relative step never falls below one count so small targets still move.
  assign w_tgtExt    = {1'b0, r_target};
  assign w_stepRaw   = w_tgtExt / DIV_X;
  assign w_step      = (w_stepRaw == '0) ? W1'(1) : w_stepRaw;
  assign w_upSum     = w_tgtExt + w_step;
  assign w_upClamp   = clampDuty(32'(w_upSum), 32'(DUTY_MIN), 32'(DUTY_MAX));
  assign w_loadClamp = clampDuty(32'(i_data), 32'(DUTY_MIN), 32'(DUTY_MAX));

  always_comb begin
    w_nextTarget = r_target;
    w_nextSat    = r_sat;
    if (i_exec) begin
      case (i_op)
        OP_UP: begin
          w_nextTarget = WIDTH'(w_upClamp.value);
          w_nextSat    = w_upClamp.hit;
        end
        OP_DOWN: begin
          if (w_tgtExt < (MIN_X + w_step)) begin
            w_nextTarget = WIDTH'(DUTY_MIN);
            w_nextSat    = 1'b1;
          end else begin
            w_nextTarget = WIDTH'(w_tgtExt - w_step);
            w_nextSat    = 1'b0;
          end
        end
        OP_LOAD: begin
          w_nextTarget = WIDTH'(w_loadClamp.value);
          w_nextSat    = w_loadClamp.hit;
        end
        default: ;
      endcase
    end
  end

  // Ramp toward the registered target, so an execute on a tick edge lands one tick later.
  assign w_diff     = (r_target >= r_duty) ? ({1'b0, r_target} - {1'b0, r_duty})
                                           : ({1'b0, r_duty} - {1'b0, r_target});
  assign w_slewStep = (w_diff > SLEW_X) ? SLEW_X : w_diff;

  always_comb begin
    w_nextDuty = r_duty;
    if (i_tick) begin
      if (r_target > r_duty) begin
        w_nextDuty = WIDTH'({1'b0, r_duty} + w_slewStep);
      end else begin
        w_nextDuty = WIDTH'({1'b0, r_duty} - w_slewStep);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_target <= WIDTH'(DUTY_INIT);
      r_duty   <= WIDTH'(DUTY_INIT);
      r_sat    <= 1'b0;
    end else begin
      r_target <= w_nextTarget;
      r_duty   <= w_nextDuty;
      r_sat    <= w_nextSat;
    end
  end

  assign o_duty     = r_duty;
  assign o_atTarget = (r_duty == r_target);
  assign o_sat      = r_sat;

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Multi-channel slew-limited duty controller: command register, channel decode,
// drop detection and the shared ramp tick feeding one lane per channel.
module duty_ramp_ctrl
  import duty_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int DUTY_MAX  = DEF_DUTY_MAX,
  parameter int DUTY_MIN  = DEF_DUTY_MIN,
  parameter int DUTY_INIT = DEF_DUTY_INIT,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int SLEW      = DEF_SLEW,
  parameter int RAMP_DIV  = DEF_RAMP_DIV,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      nrst,
  duty_ramp_ctrl_if.slave           cmd,
  output logic [CHANNELS*WIDTH-1:0] duty_out,
  output logic [CHANNELS-1:0]       at_target,
  output logic [CHANNELS-1:0]       sat,
  output logic                      cmd_err
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic             r_pending;
  op_e              r_op;
  logic [CH_W-1:0]  r_ch;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  logic                w_accept;
  logic                w_tick;
  logic                w_chValid;
  logic [CHANNELS-1:0] w_exec;

  assign w_accept      = cmd.cmd_valid && !r_pending;
  assign cmd.cmd_ready = !r_pending;
  assign w_tick        = (r_cnt == CNT_W'(RAMP_DIV - 1));

  // pending lasts exactly one cycle: the execute cycle that follows an accept.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_pending <= 1'b0;
      r_op      <= OP_NOP;
      r_ch      <= '0;
      r_data    <= '0;
    end else begin
      r_pending <= w_accept;
      if (w_accept) begin
        r_op   <= cmd.cmd_op;
        r_ch   <= cmd.cmd_ch;
        r_data <= cmd.cmd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  generate
    if (CHANNELS == (2 ** CH_W)) begin : gen_fullDecode
      assign w_chValid = 1'b1;
    end else begin : gen_partDecode
      assign w_chValid = (r_ch < CH_W'(CHANNELS));
    end
  endgenerate

  assign cmd_err = r_pending && !w_chValid;

  generate
    for (genvar n = 0; n < CHANNELS; n++) begin : gen_lane
      assign w_exec[n] = r_pending && (r_ch == CH_W'(n));

      duty_ramp_lane #(
        .WIDTH    (WIDTH),
        .DUTY_MAX (DUTY_MAX),
        .DUTY_MIN (DUTY_MIN),
        .DUTY_INIT(DUTY_INIT),
        .STEP_DIV (STEP_DIV),
        .SLEW     (SLEW)
      ) u_lane (
        .clk       (clk),
        .nrst      (nrst),
        .i_exec    (w_exec[n]),
        .i_op      (r_op),
        .i_data    (r_data),
        .i_tick    (w_tick),
        .o_duty    (duty_out[n*WIDTH +: WIDTH]),
        .o_atTarget(at_target[n]),
        .o_sat     (sat[n])
      );
    end
  endgenerate

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl: a 4-channel instance for the main features and a
// 3-channel instance for out-of-range channel drops.
module tb_duty_ramp_ctrl;
  import duty_pkg::*;

  localparam int TB_RAMP = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  duty_ramp_ctrl_if #(.WIDTH(12), .CH_W(2)) cmdA ();
  duty_ramp_ctrl_if #(.WIDTH(12), .CH_W(2)) cmdB ();

  logic [47:0] dutyA;
  logic [3:0]  atA, satA;
  logic        errA;
  logic [35:0] dutyB;
  logic [2:0]  atB, satB;
  logic        errB;

  duty_ramp_ctrl #(.CHANNELS(4)) dutA (
    .clk(clk), .nrst(nrst), .cmd(cmdA),
    .duty_out(dutyA), .at_target(atA), .sat(satA), .cmd_err(errA)
  );

  duty_ramp_ctrl #(.CHANNELS(3)) dutB (
    .clk(clk), .nrst(nrst), .cmd(cmdB),
    .duty_out(dutyB), .at_target(atB), .sat(satB), .cmd_err(errB)
  );

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;

  function automatic logic [11:0] chA(input logic [47:0] v, input int n);
    return v[n*12 +: 12];
  endfunction

  // Counts edges since reset release so ramp ticks are predicted by the bench alone.
  task automatic stepClk();
    @(posedge clk);
    if (nrst) cyc = cyc + 1;
    else      cyc = 0;
    #1;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      do stepClk(); while ((cyc % TB_RAMP) != 0);
    end
  endtask

  task automatic sendA(input logic [1:0] ch, input op_e op, input logic [11:0] data);
    cmdA.cmd_valid = 1'b1;
    cmdA.cmd_ch    = ch;
    cmdA.cmd_op    = op;
    cmdA.cmd_data  = data;
    stepClk();
    cmdA.cmd_valid = 1'b0;
    cmdA.cmd_op    = OP_NOP;
    stepClk();
  endtask

  task automatic test_reset();
    nChecks++; if (dutyA !== {4{12'd100}}) $display("[TB] FAIL reset_duty got=%h exp=%h", dutyA, {4{12'd100}}); else nPass++;
    nChecks++; if (atA !== 4'b1111) $display("[TB] FAIL reset_atTarget got=%b exp=1111", atA); else nPass++;
    nChecks++; if (satA !== 4'b0000) $display("[TB] FAIL reset_sat got=%b exp=0000", satA); else nPass++;
    nChecks++; if (cmdA.cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", cmdA.cmd_ready); else nPass++;
    nChecks++; if (errA !== 1'b0) $display("[TB] FAIL reset_err got=%b exp=0", errA); else nPass++;
  endtask

  task automatic test_stepUp();
    sendA(2'd1, OP_UP, 12'd0);
    nChecks++; if (chA(dutyA, 1) !== 12'd100) $display("[TB] FAIL up_exec_duty got=%0d exp=100", chA(dutyA, 1)); else nPass++;
    nChecks++; if (atA !== 4'b1101) $display("[TB] FAIL up_exec_atTarget got=%b exp=1101", atA); else nPass++;
    runTicks(1);
    nChecks++; if (chA(dutyA, 1) !== 12'd108) $display("[TB] FAIL up_tick1_duty got=%0d exp=108", chA(dutyA, 1)); else nPass++;
    nChecks++; if (atA[1] !== 1'b0) $display("[TB] FAIL up_tick1_atTarget got=%b exp=0", atA[1]); else nPass++;
    stepClk();
    nChecks++; if (chA(dutyA, 1) !== 12'd108) $display("[TB] FAIL up_hold_duty got=%0d exp=108", chA(dutyA, 1)); else nPass++;
    runTicks(1);
    nChecks++; if (dutyA !== {12'd100, 12'd100, 12'd110, 12'd100}) $display("[TB] FAIL up_tick2_duty got=%h exp=%h", dutyA, {12'd100, 12'd100, 12'd110, 12'd100}); else nPass++;
    nChecks++; if (atA !== 4'b1111) $display("[TB] FAIL up_tick2_atTarget got=%b exp=1111", atA); else nPass++;
  endtask

  task automatic test_clamp();
    sendA(2'd2, OP_LOAD, 12'd480);
    nChecks++; if (satA[2] !== 1'b0) $display("[TB] FAIL clamp_load480_sat got=%b exp=0", satA[2]); else nPass++;
    runTicks(64);
    nChecks++; if (chA(dutyA, 2) !== 12'd480) $display("[TB] FAIL clamp_load480_duty got=%0d exp=480", chA(dutyA, 2)); else nPass++;
    sendA(2'd2, OP_UP, 12'd0);
    nChecks++; if (satA[2] !== 1'b1) $display("[TB] FAIL clamp_up_sat got=%b exp=1", satA[2]); else nPass++;
    runTicks(64);
    nChecks++; if (chA(dutyA, 2) !== 12'd500) $display("[TB] FAIL clamp_up_duty got=%0d exp=500", chA(dutyA, 2)); else nPass++;
    sendA(2'd2, OP_DOWN, 12'd0);
    nChecks++; if (satA[2] !== 1'b0) $display("[TB] FAIL clamp_down_sat got=%b exp=0", satA[2]); else nPass++;
    runTicks(64);
    nChecks++; if (chA(dutyA, 2) !== 12'd450) $display("[TB] FAIL clamp_down_duty got=%0d exp=450", chA(dutyA, 2)); else nPass++;
    sendA(2'd2, OP_LOAD, 12'd4000);
    nChecks++; if (satA[2] !== 1'b1) $display("[TB] FAIL clamp_load4000_sat got=%b exp=1", satA[2]); else nPass++;
    runTicks(64);
    nChecks++; if (chA(dutyA, 2) !== 12'd500) $display("[TB] FAIL clamp_load4000_duty got=%0d exp=500", chA(dutyA, 2)); else nPass++;
    nChecks++; if (atA !== 4'b1111) $display("[TB] FAIL clamp_atTarget got=%b exp=1111", atA); else nPass++;
  endtask

  task automatic test_minStep();
    sendA(2'd0, OP_LOAD, 12'd5);
    runTicks(64);
    nChecks++; if (chA(dutyA, 0) !== 12'd5) $display("[TB] FAIL min_load5_duty got=%0d exp=5", chA(dutyA, 0)); else nPass++;
    sendA(2'd0, OP_DOWN, 12'd0);
    runTicks(2);
    nChecks++; if (chA(dutyA, 0) !== 12'd4) $display("[TB] FAIL min_down_duty got=%0d exp=4", chA(dutyA, 0)); else nPass++;
    nChecks++; if (satA[0] !== 1'b0) $display("[TB] FAIL min_down_sat got=%b exp=0", satA[0]); else nPass++;
    sendA(2'd0, OP_LOAD, 12'd0);
    sendA(2'd0, OP_DOWN, 12'd0);
    nChecks++; if (satA[0] !== 1'b1) $display("[TB] FAIL floor_sat got=%b exp=1", satA[0]); else nPass++;
    runTicks(2);
    nChecks++; if (chA(dutyA, 0) !== 12'd0) $display("[TB] FAIL floor_duty got=%0d exp=0", chA(dutyA, 0)); else nPass++;
    nChecks++; if (atA[0] !== 1'b1) $display("[TB] FAIL floor_atTarget got=%b exp=1", atA[0]); else nPass++;
  endtask

  task automatic test_back_to_back();
    logic expReady [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cmdA.cmd_valid = 1'b1;
    cmdA.cmd_ch    = 2'd3;
    cmdA.cmd_op    = OP_UP;
    cmdA.cmd_data  = 12'd0;
    for (int i = 0; i < 5; i++) begin
      nChecks++; if (cmdA.cmd_ready !== expReady[i]) $display("[TB] FAIL b2b_ready[%0d] got=%b exp=%b", i, cmdA.cmd_ready, expReady[i]); else nPass++;
      stepClk();
    end
    cmdA.cmd_valid = 1'b0;
    cmdA.cmd_op    = OP_NOP;
    nChecks++; if (cmdA.cmd_ready !== 1'b0) $display("[TB] FAIL b2b_ready_last got=%b exp=0", cmdA.cmd_ready); else nPass++;
    stepClk();
    runTicks(64);
    nChecks++; if (chA(dutyA, 3) !== 12'd133) $display("[TB] FAIL b2b_chain_duty got=%0d exp=133", chA(dutyA, 3)); else nPass++;
    nChecks++; if (satA[3] !== 1'b0) $display("[TB] FAIL b2b_sat got=%b exp=0", satA[3]); else nPass++;
  endtask

  task automatic test_resetMidRamp();
    sendA(2'd3, OP_LOAD, 12'd400);
    runTicks(2);
    nChecks++; if (chA(dutyA, 3) !== 12'd149) $display("[TB] FAIL midramp_duty got=%0d exp=149", chA(dutyA, 3)); else nPass++;
    nrst = 1'b0;
    stepClk();
    nChecks++; if (dutyA !== {4{12'd100}}) $display("[TB] FAIL midramp_rst_duty got=%h exp=%h", dutyA, {4{12'd100}}); else nPass++;
    nChecks++; if (atA !== 4'b1111) $display("[TB] FAIL midramp_rst_atTarget got=%b exp=1111", atA); else nPass++;
    nChecks++; if (satA !== 4'b0000) $display("[TB] FAIL midramp_rst_sat got=%b exp=0000", satA); else nPass++;
    nrst = 1'b1;
    nChecks++; if (cmdA.cmd_ready !== 1'b1) $display("[TB] FAIL midramp_rst_ready got=%b exp=1", cmdA.cmd_ready); else nPass++;
    sendA(2'd0, OP_UP, 12'd0);
    nChecks++; if (atA !== 4'b1110) $display("[TB] FAIL postrst_atTarget got=%b exp=1110", atA); else nPass++;
    runTicks(1);
    nChecks++; if (chA(dutyA, 0) !== 12'd108) $display("[TB] FAIL postrst_tick_duty got=%0d exp=108", chA(dutyA, 0)); else nPass++;
  endtask

  task automatic test_dropErr();
    cmdB.cmd_valid = 1'b1;
    cmdB.cmd_ch    = 2'd3;
    cmdB.cmd_op    = OP_UP;
    cmdB.cmd_data  = 12'd0;
    stepClk();
    cmdB.cmd_valid = 1'b0;
    cmdB.cmd_op    = OP_NOP;
    nChecks++; if (errB !== 1'b1) $display("[TB] FAIL drop_err_pulse got=%b exp=1", errB); else nPass++;
    nChecks++; if (cmdB.cmd_ready !== 1'b0) $display("[TB] FAIL drop_ready got=%b exp=0", cmdB.cmd_ready); else nPass++;
    stepClk();
    nChecks++; if (errB !== 1'b0) $display("[TB] FAIL drop_err_end got=%b exp=0", errB); else nPass++;
    nChecks++; if (atB !== 3'b111) $display("[TB] FAIL drop_atTarget got=%b exp=111", atB); else nPass++;
    runTicks(2);
    nChecks++; if (dutyB !== {3{12'd100}}) $display("[TB] FAIL drop_duty got=%h exp=%h", dutyB, {3{12'd100}}); else nPass++;
    nChecks++; if (satB !== 3'b000) $display("[TB] FAIL drop_sat got=%b exp=000", satB); else nPass++;
    cmdB.cmd_valid = 1'b1;
    cmdB.cmd_ch    = 2'd2;
    cmdB.cmd_op    = OP_LOAD;
    cmdB.cmd_data  = 12'd200;
    stepClk();
    cmdB.cmd_valid = 1'b0;
    cmdB.cmd_op    = OP_NOP;
    nChecks++; if (errB !== 1'b0) $display("[TB] FAIL valid_ch_err got=%b exp=0", errB); else nPass++;
    stepClk();
    nChecks++; if (atB !== 3'b011) $display("[TB] FAIL valid_ch_atTarget got=%b exp=011", atB); else nPass++;
    runTicks(64);
    nChecks++; if (dutyB[24 +: 12] !== 12'd200) $display("[TB] FAIL valid_ch_duty got=%0d exp=200", dutyB[24 +: 12]); else nPass++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired after %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cmdA.cmd_valid = 1'b0;
    cmdA.cmd_ch    = '0;
    cmdA.cmd_op    = OP_NOP;
    cmdA.cmd_data  = '0;
    cmdB.cmd_valid = 1'b0;
    cmdB.cmd_ch    = '0;
    cmdB.cmd_op    = OP_NOP;
    cmdB.cmd_data  = '0;
    nrst = 1'b0;
    stepClk();
    stepClk();
    nrst = 1'b1;

    test_reset();
    test_stepUp();
    test_clamp();
    test_minStep();
    test_back_to_back();
    test_resetMidRamp();
    test_dropErr();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/duty_ramp_ctrl.md
# duty_ramp_ctrl

Multi-channel PWM duty-cycle controller that holds a per-channel target duty and slews each output toward its target at a bounded rate. Commands arrive over a valid/ready port: percentage step up, step down, or absolute load. Sits between the command/data receive path and the PWM generators. Compared with the single-channel adjuster, it adds parametrised width and channel count, clamping at both ends, a minimum step, slew limiting, and per-channel status.

## Interface
- WIDTH, 12: duty word width.
- CHANNELS, 4: number of independent channels; CH_W = max(1, $clog2(CHANNELS)).
- DUTY_MAX, 500: upper clamp; must be < 2^WIDTH.
- DUTY_MIN, 0: lower clamp.
- DUTY_INIT, 100: reset duty; DUTY_MIN <= DUTY_INIT <= DUTY_MAX.
- STEP_DIV, 10: relative step is target/STEP_DIV; must be >= 1.
- SLEW, 8: maximum duty_out change per ramp tick; must be >= 1.
- RAMP_DIV, 4: clk cycles per ramp tick; must be >= 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- nrst  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_ch  in  CH_W  target channel.
- cmd_op  in  2  00 nop, 01 step up, 10 step down, 11 load.
- cmd_data  in  WIDTH  load value; ignored for other ops.
- duty_out  out  CHANNELS*WIDTH  current duty; channel n at [n*WIDTH +: WIDTH].
- at_target  out  CHANNELS  duty_out equals target for that channel.
- sat  out  CHANNELS  sticky; last applied command on that channel was clamped.
- cmd_err  out  1  one-cycle pulse on a dropped command.

## Operation
- Handshake: a command is accepted when cmd_valid && cmd_ready. The accepted op, channel and data are registered and pending is set. cmd_ready = !pending. The command executes the next cycle, which clears pending. Maximum throughput is one command per 2 cycles.
- Execution, with t = the channel's current target. All arithmetic uses WIDTH+1 bits.
  - Step size: d = t/STEP_DIV; if d == 0, d = 1.
  - Up: n = t + d; if n > DUTY_MAX, n = DUTY_MAX and sat = 1, else sat = 0.
  - Down: if t < DUTY_MIN + d, n = DUTY_MIN and sat = 1, else n = t - d and sat = 0.
  - Load: n = clamp(cmd_data, DUTY_MIN, DUTY_MAX); sat = 1 if a clamp occurred.
  - Nop: no change; sat unchanged.
- Drop rule: if cmd_ch >= CHANNELS, the command is accepted, cmd_err pulses on the execute cycle, and no state changes.
- Ramp: a free-running counter runs 0..RAMP_DIV-1, and tick = (count == RAMP_DIV-1). On each tick, every channel moves duty_out toward its target by min(SLEW, |target - duty_out|). Between ticks duty_out holds.
- at_target[n] = (duty_out[n] == target[n]), combinational from registers.

## Timing
- Reset (nrst low at a clk edge) sets:
  - targets and duty_out to DUTY_INIT;
  - sat, cmd_err, pending and the ramp counter to 0;
  - cmd_ready to 1 and at_target to all ones.
- Reset mid-ramp or with a command pending abandons everything; the first command can be accepted on the first cycle with nrst high.
- Latency:
  - Accept at cycle N; target and sat update at edge N+1; cmd_ready high again in cycle N+1.
  - duty_out first moves on the first tick at or after N+2.
- If the execute cycle coincides with a tick, the ramp uses the pre-update target; the new target takes effect on the following tick.
- Sequential commands to one channel chain on the updated target; there is no lost update.
- The ramp counter is never reset by commands.

## Structure
- Package duty_pkg holds:
  - the op encodings (OP_NOP, OP_UP, OP_DOWN, OP_LOAD);
  - default parameter values;
  - a clamp function shared by load and step.
- Sub-module duty_ramp_lane, instantiated CHANNELS times. Each lane holds the target, duty_out and sat registers, the step/clamp datapath, and the slew step.
- The top level owns the command register, pending/ready, channel decode, cmd_err, and the shared tick counter.

## Test plan
- Reset, default parameters: every duty_out = 100, at_target = 4'b1111, sat = 0, cmd_ready = 1.
- Step up on ch1: target 100 -> 110. duty_out[1] goes 100 -> 108 -> 110 on two successive ticks. at_target[1] is low between execute and the second tick; other channels stay at 100.
- Clamp up: load 480 on ch2, then step up. Target becomes 500 (528 clamped) and sat[2] = 1. A following step down gives 450 and sat[2] = 0. Load 4000 gives 500 with sat[2] = 1.
- Minimum step and floor: load 5 on ch0, then step down -> 4 (d = 1). Load 0, then step down -> stays 0 with sat[0] = 1.
- Handshake and error: cmd_valid held high with three commands gives accepts on alternate cycles only. With CHANNELS = 3, cmd_ch = 3 -> cmd_err pulses for one cycle and no target changes.
- Reset mid-ramp: load 400 on ch3, then assert nrst low after 2 ticks. Next cycle duty_out[3] = 100, target = 100, and cmd_ready = 1 once nrst is high.
